// File: rtl/spi_slv_pkg.sv
// rtl/spi_slv_pkg.sv - opcodes, status signature, frame edge indices and FSM states for spi_slv_bridge
package spi_slv_pkg;

  localparam logic [7:0] OP_WR      = 8'h00;
  localparam logic [7:0] OP_RD      = 8'h01;
  localparam logic [3:0] STATUS_SIG = 4'h5;

  // Rising-edge numbers (1-based from ss_n fall) that close each frame field.
  localparam logic [6:0] EDGE_INSTR_LAST = 7'd8;
  localparam logic [6:0] EDGE_ADDR_LAST  = 7'd41;
  localparam logic [6:0] EDGE_WDATA_LAST = 7'd73;
  // Edge count at the falling edges where the outgoing shift register is loaded.
  localparam logic [6:0] EDGE_RD_LOAD    = 7'd48;
  localparam logic [6:0] EDGE_STAT_LOAD  = 7'd80;
  // Edge count at the falling edge after the last status bit has been sampled.
  localparam logic [6:0] EDGE_LAST       = 7'd88;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_STAT    = 3'd5,
    ST_DRAIN   = 3'd6
  } state_t;

endpackage

// File: rtl/spi_slv_sync_edge.sv
// rtl/spi_slv_sync_edge.sv - synchronizers for sck/ss_n/mosi plus edge detection in the clk domain
// Ports: clk, rst (sync, active-high); sck, ss_n, mosi asynchronous inputs;
//        sck_rise/sck_fall/ss_rise/ss_fall one-cycle pulses; mosi_s synchronized mosi.
// SYNC_STAGES must be >= 2.
module spi_slv_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic ss_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_rise,
  output logic ss_fall,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   ss_prev_q, ss_prev_d;

  // mosi goes through the same depth as sck so a sampled bit lines up with its edge.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sck_prev_d  = sck_sync_q[SYNC_STAGES-1];
    ss_prev_d   = ss_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      ss_prev_q   <= ss_prev_d;
    end
  end

  assign sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
  assign ss_rise  = ss_sync_q[SYNC_STAGES-1] & ~ss_prev_q;
  assign ss_fall  = ~ss_sync_q[SYNC_STAGES-1] & ss_prev_q;
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slv_bridge.sv
// rtl/spi_slv_bridge.sv - SPI mode-0 slave turning fixed 89-edge frames into 32-bit bus transactions
// Ports: clk, rst (sync, active-high); sck, ss_n, mosi, miso SPI side;
//        bus_req/bus_we/bus_addr/bus_wdata request, bus_rdata/bus_ack completion.
// Macro SPI_BUS_TIMEOUT_EN: builds a TIMEOUT_CYC-cycle bus_ack timeout that drops bus_req and flags err.
module spi_slv_bridge
  import spi_slv_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        ss_n,
  input  logic        mosi,
  output logic        miso,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  logic sck_rise, sck_fall, ss_rise, ss_fall, mosi_s;

  spi_slv_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_rise  (ss_rise),
    .ss_fall  (ss_fall),
    .mosi_s   (mosi_s)
  );

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [31:0] rx_q, rx_d;
  logic [39:0] tx_q, tx_d;
  logic        miso_q, miso_d;
  logic        rd_q, rd_d;
  logic [31:0] addr_q, addr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        bad_q, bad_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic        timeout_hit;
  logic [31:0] rx_shift;
  logic [6:0]  cnt_inc;
  logic [7:0]  status;
  logic [39:0] load_v;
  logic        load;

`ifdef SPI_BUS_TIMEOUT_EN
  localparam int              TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts cycles of an outstanding request; bus_req is high for TIMEOUT_CYC cycles at most.
  always_comb begin
    to_cnt_d = '0;
    if (bus_req_q && !bus_ack && !timeout_hit) to_cnt_d = to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end

  assign timeout_hit = bus_req_q && (to_cnt_q == TO_LAST);
`else
  logic timeout_cfg_unused;
  assign timeout_cfg_unused = (TIMEOUT_CYC > 0);
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    done_d      = done_q;
    err_d       = err_q;
    bad_d       = bad_q;
    res_valid_d = res_valid_q;
    rdata_d     = rdata_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rx_shift    = {rx_q[30:0], mosi_s};
    cnt_inc     = cnt_q + 7'd1;
    status      = {STATUS_SIG, 1'b0, bad_q, err_q, done_q};
    load_v      = '0;
    load        = 1'b0;

    // Bus completion. res_valid marks a request whose result still belongs to the
    // current frame; results of aborted or already-reported requests are dropped.
    if (bus_req_q && bus_ack) begin
      bus_req_d = 1'b0;
      if (res_valid_q) begin
        done_d      = 1'b1;
        rdata_d     = bus_rdata;
        res_valid_d = 1'b0;
      end
    end else if (timeout_hit) begin
      bus_req_d = 1'b0;
      if (res_valid_q) begin
        err_d       = 1'b1;
        res_valid_d = 1'b0;
      end
    end

    if (ss_rise) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      miso_d      = 1'b0;
      tx_d        = '0;
      res_valid_d = 1'b0;
    end else if (ss_fall) begin
      state_d     = ST_CMD;
      cnt_d       = '0;
      miso_d      = 1'b0;
      tx_d        = '0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      bad_d       = 1'b0;
      res_valid_d = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (sck_rise) begin
        cnt_d = cnt_inc;
        rx_d  = rx_shift;
        case (state_q)
          ST_CMD: begin
            if (cnt_inc == EDGE_INSTR_LAST) begin
              if (rx_shift[7:0] == OP_WR || rx_shift[7:0] == OP_RD) begin
                rd_d    = (rx_shift[7:0] == OP_RD);
                state_d = ST_ADDR;
              end else begin
                bad_d   = 1'b1;
                state_d = ST_DRAIN;
              end
            end
          end
          // Edge 9 shifts in too but is pushed out of rx before edge 41.
          ST_ADDR: begin
            if (cnt_inc == EDGE_ADDR_LAST) begin
              addr_d = rx_shift;
              if (rd_q) begin
                state_d     = ST_RD_WAIT;
                bus_req_d   = 1'b1;
                bus_we_d    = 1'b0;
                bus_addr_d  = rx_shift;
                res_valid_d = 1'b1;
              end else begin
                state_d = ST_WR_DATA;
              end
            end
          end
          ST_WR_DATA: begin
            if (cnt_inc == EDGE_WDATA_LAST) begin
              bus_req_d   = 1'b1;
              bus_we_d    = 1'b1;
              bus_addr_d  = addr_q;
              bus_wdata_d = rx_shift;
              res_valid_d = 1'b1;
            end
          end
          default: ;
        endcase
      end else if (sck_fall) begin
        case (state_q)
          // Read data is frozen here: a later ack neither changes data nor sets done.
          ST_RD_WAIT: begin
            if (cnt_q == EDGE_RD_LOAD) begin
              load   = 1'b1;
              load_v = {(done_q ? rdata_q : 32'h0), status};
            end
          end
          ST_WR_DATA, ST_DRAIN: begin
            if (cnt_q == EDGE_STAT_LOAD) begin
              load   = 1'b1;
              load_v = {status, 32'h0};
            end
          end
          ST_STAT: begin
            if (cnt_q == EDGE_LAST) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
              miso_d  = 1'b0;
              tx_d    = '0;
            end else begin
              miso_d = tx_q[39];
              tx_d   = {tx_q[38:0], 1'b0};
            end
          end
          default: ;
        endcase
        if (load) begin
          state_d     = ST_STAT;
          miso_d      = load_v[39];
          tx_d        = {load_v[38:0], 1'b0};
          done_d      = done_q;
          err_d       = err_q;
          res_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bad_q       <= 1'b0;
      res_valid_q <= 1'b0;
      rdata_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
      err_q       <= err_d;
      bad_q       <= bad_d;
      res_valid_q <= res_valid_d;
      rdata_q     <= rdata_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign miso      = miso_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_spi_slv_bridge.sv
// tb/tb_spi_slv_bridge.sv - self-checking bench for spi_slv_bridge with a frame-level reference model
module tb_spi_slv_bridge;

  localparam int H  = 6;
  localparam int TO = 32;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck;
  logic        ss_n;
  logic        mosi;
  logic        miso;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int          checks = 0;
  int          errors = 0;
  int          ack_delay = -1;
  logic [31:0] rd_value = '0;
  int          last_req_len = 0;
  txn_t        txq[$];

  always #5 clk = ~clk;

  spi_slv_bridge #(.SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .sck       (sck),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  // Bus responder: logs each new request and acks it ack_delay cycles later (never if < 0).
  initial begin
    logic req_prev;
    int   wait_cnt;
    int   req_cur;
    req_prev  = 1'b0;
    wait_cnt  = 0;
    req_cur   = 0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = $urandom();
      if (bus_req) begin
        if (!req_prev) begin
          txq.push_back('{we: bus_we, addr: bus_addr, wdata: bus_wdata});
          wait_cnt = 0;
          req_cur  = 1;
        end else begin
          wait_cnt++;
          req_cur++;
        end
        if (ack_delay >= 0 && wait_cnt == ack_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = rd_value;
        end
      end else if (req_prev) begin
        last_req_len = req_cur;
        req_cur      = 0;
      end
      req_prev = bus_req;
    end
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_status(input logic [7:0] op, input bit acked, input bit tmo);
    bit bad;
    bad = (op != 8'h00) && (op != 8'h01);
    return {4'h5, 1'b0, bad, (bad ? 1'b0 : tmo), (bad ? 1'b0 : acked)};
  endfunction

  // Expected miso value seen by the master at each rising edge k (bit k of the result).
  function automatic logic [95:0] model_miso(input logic [7:0] op, input logic [31:0] rdv,
                                             input bit acked, input bit tmo);
    logic [95:0] m;
    logic [7:0]  st;
    m  = '0;
    st = model_status(op, acked, tmo);
    for (int k = 49; k <= 80; k++) begin
      if (op == 8'h01 && acked) m[k] = rdv[80-k];
    end
    for (int k = 81; k <= 88; k++) m[k] = st[88-k];
    return m;
  endfunction

  task automatic spi_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                           input int n_edges, input int rst_edge, output logic [95:0] got);
    logic [88:0] txv;
    txv  = {op, 1'b0, a, d, 16'h0};
    got  = '0;
    ss_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int k = 1; k <= n_edges; k++) begin
      mosi = (k <= 89) ? txv[89-k] : 1'b0;
      repeat (H) @(negedge clk);
      got[k] = miso;
      sck = 1'b1;
      repeat (H) @(negedge clk);
      sck = 1'b0;
      if (k == rst_edge) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_miso", miso, 1'b0);
        check("rst_mid_bus_req", bus_req, 1'b0);
        rst = 1'b0;
        break;
      end
    end
    repeat (H) @(negedge clk);
    ss_n = 1'b1;
    mosi = 1'b0;
    repeat (4 * H) @(negedge clk);
  endtask

  task automatic run_and_check(input string tag, input logic [7:0] op, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] rdv, input int dly,
                               input bit acked, input bit tmo, output logic [7:0] st_got);
    logic [95:0] got;
    logic [31:0] rd_got;
    txn_t        t;
    ack_delay = dly;
    rd_value  = rdv;
    spi_frame(op, a, d, 89, 0, got);
    st_got = '0;
    rd_got = '0;
    for (int k = 49; k <= 80; k++) rd_got = {rd_got[30:0], got[k]};
    for (int k = 81; k <= 88; k++) st_got = {st_got[6:0], got[k]};
    check({tag, "_status"}, st_got, model_status(op, acked, tmo));
    if (op == 8'h01) check({tag, "_rdata"}, rd_got, (acked ? rdv : 32'h0));
    check({tag, "_miso"}, got, model_miso(op, rdv, acked, tmo));
    if (op == 8'h00 || op == 8'h01) begin
      check({tag, "_txn_count"}, txq.size(), 1);
      if (txq.size() > 0) begin
        t = txq.pop_front();
        check({tag, "_we"}, t.we, (op == 8'h00));
        check({tag, "_addr"}, t.addr, a);
        if (op == 8'h00) check({tag, "_wdata"}, t.wdata, d);
      end
    end else begin
      check({tag, "_txn_count"}, txq.size(), 0);
    end
    txq.delete();
  endtask

  initial begin
    logic [95:0] got;
    logic [7:0]  st;
    logic [7:0]  op;
    logic [31:0] a, d, rdv;
    int          sel;

    rst  = 1'b1;
    sck  = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_miso", miso, 1'b0);
    check("reset_bus_req", bus_req, 1'b0);
    check("reset_bus_we", bus_we, 1'b0);
    check("reset_bus_addr", bus_addr, 32'h0);
    check("reset_bus_wdata", bus_wdata, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    run_and_check("t1_wr", 8'h00, 32'h10, 32'hDEADBEEF, $urandom(), 2, 1'b1, 1'b0, st);
    check("t1_status_const", st, 8'h51);
    check("t1_bus_idle", bus_req, 1'b0);

    run_and_check("t2_rd", 8'h01, 32'h10, $urandom(), 32'hCAFEF00D, 3, 1'b1, 1'b0, st);
    check("t2_status_const", st, 8'h51);

    run_and_check("t3_bad", 8'h7E, $urandom(), $urandom(), $urandom(), 2, 1'b1, 1'b0, st);
    check("t3_status_const", st, 8'h54);

    ack_delay = 2;
    spi_frame(8'h01, 32'h0000_0100, $urandom(), 20, 0, got);
    run_and_check("t4_rd", 8'h01, 32'h4, $urandom(), $urandom(), 4, 1'b1, 1'b0, st);
    check("t4_status_const", st, 8'h51);

`ifdef SPI_BUS_TIMEOUT_EN
    run_and_check("t5_tmo", 8'h01, $urandom(), $urandom(), $urandom(), -1, 1'b0, 1'b1, st);
    check("t5_status_const", st, 8'h52);
    check("t5_req_len", last_req_len, TO);
`else
    run_and_check("t5_noack", 8'h01, $urandom(), $urandom(), $urandom(), -1, 1'b0, 1'b0, st);
    check("t5_status_const", st, 8'h50);
    check("t5_req_held", bus_req, 1'b1);
`endif

    ack_delay = -1;
    spi_frame(8'h01, $urandom(), $urandom(), 89, 43, got);
    txq.delete();
    ack_delay = 2;
    spi_frame(8'h00, $urandom(), $urandom(), 89, 84, got);
    txq.delete();
    run_and_check("t6_wr", 8'h00, $urandom(), $urandom(), $urandom(), 1, 1'b1, 1'b0, st);
    check("t6_status_const", st, 8'h51);

    for (int i = 0; i < 8; i++) begin
      sel = $urandom_range(0, 2);
      op  = (sel == 0) ? 8'h00 : (sel == 1) ? 8'h01 : 8'($urandom_range(2, 255));
      a   = $urandom();
      d   = $urandom();
      rdv = $urandom();
      run_and_check("rnd", op, a, d, rdv, $urandom_range(0, 20), 1'b1, 1'b0, st);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
